// File: rtl/block_mult_pkg.sv
// Shared types and helpers for the block-multiply output sequencers.
// Holds the serializer state encoding, the default word width and the index-width helper.
package block_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 16;

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_index_counter.sv
// Up/down modulo-COUNT_N index counter with synchronous load, count enable and terminal flag.
// Wraps explicitly at the modulo boundary, so non-power-of-two frame sizes never overflow into unused codes.
module frame_index_counter #(
  parameter int COUNT_N = 4,
  parameter int CNT_W   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  input  logic             down,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(COUNT_N - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      if (down) count <= (count == '0) ? TOP : count - CNT_W'(1);
      else      count <= (count == TOP) ? '0 : count + CNT_W'(1);
    end
  end

  // Terminal is the last index visited in the current direction.
  assign terminal = down ? (count == '0) : (count == TOP);

endmodule

// File: rtl/block_serializer.sv
// Captures a NUM_IN-word frame with valid/ready and replays it one word per beat with index/last markers.
// Optional BLOCK_SERIALIZER_DIR_EN adds in_dir to replay a frame in descending word order.
module block_serializer
  import block_mult_pkg::*;
#(
  parameter int  DATA_W = DEFAULT_DATA_W,
  parameter int  NUM_IN = 4,
  localparam int IDX_W  = idx_width(NUM_IN)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
`ifdef BLOCK_SERIALIZER_DIR_EN
  input  logic                     in_dir,
`endif
  output logic                     busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] frame_q [NUM_IN];
  logic [IDX_W-1:0]  idx, load_value;
  logic              dir_in, dir_q;
  logic              accept, beat, last_beat, terminal, cnt_load, cnt_en;

  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && out_last;

`ifdef BLOCK_SERIALIZER_DIR_EN
  assign dir_in = in_dir;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       dir_q <= 1'b0;
    else if (accept) dir_q <= dir_in;
  end
`else
  assign dir_in = 1'b0;
  assign dir_q  = 1'b0;
`endif

  // A new frame loads its start index; a final beat with no successor parks idx at zero.
  assign cnt_load   = accept || last_beat;
  assign load_value = (accept && dir_in) ? LAST_IDX : '0;
  assign cnt_en     = beat && !out_last;

  frame_index_counter #(
    .COUNT_N (NUM_IN),
    .CNT_W   (IDX_W)
  ) u_index (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (load_value),
    .enable     (cnt_en),
    .down       (dir_q),
    .count      (idx),
    .terminal   (terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_IN; k++) frame_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_IN; k++) frame_q[k] <= in_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (last_beat && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = frame_q[idx];
        out_index = idx;
        out_last  = terminal;
        in_ready  = terminal && out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/block_serializer.md
Name: block_serializer

Overview:
- Parametrised successor to the free-running 4:1 output multiplexer in the block-multiply datapath.
- Captures a frame of NUM_IN words in parallel with a valid/ready handshake, then emits the words one per beat on a valid/ready stream, with index and last markers.
- Sits between the parallel partial-product/accumulator outputs of a multiply block and the serial write-back path.
- Replaces free-running selection with flow-controlled, frame-aligned sequencing.

Parameters:
- DATA_W, 16, width of each word.
- NUM_IN, 4, words per frame; legal values are 2..64.
- IDX_W, $clog2(NUM_IN), width of out_index. This is a derived localparam and must not be overridden.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  frame present on in_data
- in_ready  out  1  block can accept a frame this cycle
- in_data  in  NUM_IN*DATA_W  packed frame; word k is in_data[k*DATA_W +: DATA_W]
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the current beat
- out_data  out  DATA_W  current word
- out_index  out  IDX_W  index k of the current word
- out_last  out  1  current beat is the final word of the frame
- busy  out  1  a frame is held (state SEND)

Behaviour:
- Registers: frame buffer of NUM_IN x DATA_W, index counter idx (IDX_W bits), state {IDLE, SEND}.
- Reset (async, active-high) forces:
  - state=IDLE, idx=0, buffer=0
  - out_valid=0, out_data=0, out_index=0, out_last=0, busy=0
  - in_ready=1 combinationally while state is IDLE.
- Reset mid-frame discards the held frame. No partial beats are emitted after reset releases.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&&in_ready: capture the whole frame, set idx=0, go to SEND.
- SEND:
  - out_valid=1, out_data=buffer[idx], out_index=idx, out_last=(idx==NUM_IN-1). Outputs are driven from registers/buffer; there is no combinational path from in_data to out_data.
  - Beat transfers on out_valid&&out_ready. If idx<NUM_IN-1, idx increments.
  - Backpressure: while out_ready=0, out_data, out_index and out_last hold stable, and idx does not advance.
- Frame end and back-to-back:
  - in_ready = (state==IDLE) || (state==SEND && out_last && out_ready).
  - On the last-beat transfer, a simultaneous in_valid captures the new frame, sets idx=0 and stays in SEND. Throughput is then exactly NUM_IN beats per frame, with no bubble.
  - On the last-beat transfer with in_valid=0: go to IDLE and set idx=0.
- Latency: the first word appears on out_data the cycle after frame acceptance.
- in_data is ignored whenever in_ready=0. The upstream must hold in_valid and in_data until the handshake completes.
- idx never exceeds NUM_IN-1. For NUM_IN that is not a power of two, idx wraps explicitly at NUM_IN-1, not by counter overflow.

Optional Feature:
- Macro: BLOCK_SERIALIZER_DIR_EN.
- Defined:
  - Adds input port in_dir (1 bit), sampled with each accepted frame.
  - in_dir=0: emit words in the order 0..NUM_IN-1.
  - in_dir=1: emit words in the order NUM_IN-1..0. idx starts at NUM_IN-1 and decrements; out_last is asserted at idx==0. out_index always reports the true word index.
- Undefined: the port is absent and order is always ascending. Behaviour is otherwise identical.

Decomposition:
- Package block_mult_pkg holds:
  - the state enum (IDLE, SEND)
  - the default DATA_W=16
  - a helper function idx_width(n) that returns max(1, $clog2(n)).
- Natural sub-module: frame_index_counter. It provides an up/down modulo-NUM_IN counter with load, enable, and terminal-count output, and is reusable by other block sequencers.

Test Plan:
- Reset then a single frame {0x0001,0x0002,0x0003,0x0004}, out_ready=1:
  - out_data is 1,2,3,4 on four consecutive cycles, starting one cycle after acceptance.
  - out_index is 0..3; out_last is high only on 0x0004.
  - Then out_valid=0 and in_ready=1.
- Back-to-back frames A and B, in_valid held high, out_ready=1:
  - 8 consecutive beats with no bubble.
  - in_ready is high only in the cycle of A's last beat.
- Backpressure: drop out_ready for 3 cycles after beat 1 of {0xAAAA,0xBBBB,0xCCCC,0xDDDD}:
  - out_data holds 0xBBBB with out_index=1 for all 3 cycles.
  - Sequence then resumes with no loss or duplication.
- Assert reset while in SEND with idx=2:
  - Outputs go to 0 immediately, asynchronously.
  - After release, in_ready=1 and no stale words are emitted.
- NUM_IN=3, DATA_W=8, frame {0x11,0x22,0x33}:
  - idx wraps after 2; out_last is on 0x33.
  - Next frame starts at index 0.
- With BLOCK_SERIALIZER_DIR_EN and in_dir=1 on {1,2,3,4}:
  - out_data is 4,3,2,1 and out_index is 3,2,1,0.
  - out_last is on index 0.
